fpu_dispatch: RTL and testbench

- Upstream issue stage for the FPU core.
- Accepts `fpu_instruction_t` words on a valid/ready input and buffers them in a DEPTH-entry FIFO.
- Issues at most one instruction per cycle onto the FPU input (`fpu_i`, as driven through the interface IN modport).
- Tracks in-flight operations with a fixed-latency tag pipeline, then captures the FPU result and flags (OUT modport signals) into a tagged result port and a sticky exception register.

---
 rtl/fpu_dispatch_pkg.sv | 46 ++++
 rtl/fpu_dispatch_fifo.sv | 62 ++++++
 rtl/fpu_dispatch.sv | 119 +++++++++++
 tb/tb_fpu_dispatch.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_dispatch_pkg.sv
// Shared FPU types: instruction word, result word, exception flags and latency default.
package definitions;

    typedef enum logic [2:0] {
        FPU_ADD = 3'd0,
        FPU_SUB = 3'd1,
        FPU_MUL = 3'd2,
        FPU_DIV = 3'd3,
        FPU_I2F = 3'd4,
        FPU_F2I = 3'd5,
        FPU_REM = 3'd6
    } fpu_op_t;

    typedef enum logic [1:0] {
        RM_NEAREST_EVEN = 2'd0,
        RM_ZERO         = 2'd1,
        RM_UP           = 2'd2,
        RM_DOWN         = 2'd3
    } fpu_rmode_t;

    typedef logic [31:0] float_t;

    typedef struct packed {
        fpu_op_t    op;
        fpu_rmode_t rmode;
        float_t     opa;
        float_t     opb;
    } fpu_instruction_t;

    // Bit 7 down to bit 0, same order as the FPU flag outputs.
    typedef struct packed {
        logic inf;
        logic snan;
        logic qnan;
        logic ine;
        logic overflow;
        logic underflow;
        logic zero;
        logic div_by_zero;
    } fpu_flags_t;

    localparam int FPU_INSTR_W     = 69;
    localparam int FPU_FLAGS_W     = 8;
    localparam int FPU_LAT_DEFAULT = 4;

endpackage

// File: rtl/fpu_dispatch_fifo.sv
// Synchronous instruction FIFO with occupancy count; head word is visible combinationally.
module fpu_instr_fifo
    import definitions::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = FPU_INSTR_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Writes are refused when full and reads when empty, so the count never leaves 0..DEPTH.
    assign w_push  = i_push && (r_count != CW'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_dispatch.sv
// FPU issue stage: buffers tagged instructions, issues one per cycle, and returns
// tagged results after a fixed FPU latency while accumulating sticky exception flags.
module fpu_dispatch
    import definitions::*;
#(
    parameter int DEPTH   = 8,
    parameter int FPU_LAT = FPU_LAT_DEFAULT,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  fpu_instruction_t in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output fpu_instruction_t fpu_i,
    input  float_t           fpu_out,
    input  fpu_flags_t       fpu_flags,
    output logic             res_valid,
    output float_t           res_data,
    output fpu_flags_t       res_flags,
    output logic [TAG_W-1:0] res_tag,
    output fpu_flags_t       sticky_flags,
    input  logic             sticky_clr,
    output logic             busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = FPU_INSTR_W + TAG_W;

    logic [CW-1:0]            w_count;
    logic [FW-1:0]            w_head;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_cap;

    fpu_instruction_t         r_fpu_i;
    logic [FPU_LAT-1:0]       r_vld_p;
    logic [TAG_W-1:0]         r_tag_p [FPU_LAT];

    logic                     r_res_valid;
    logic [31:0]              r_res_data;
    logic [FPU_FLAGS_W-1:0]   r_res_flags;
    logic [TAG_W-1:0]         r_res_tag;
    logic [FPU_FLAGS_W-1:0]   r_sticky;

    // Ready depends only on the registered count, never on the downstream pop.
    assign in_ready = (w_count != CW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (w_count != '0);
    assign w_cap    = r_vld_p[FPU_LAT-1];

    fpu_instr_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_data  ({in_instr, in_tag}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

    // Issue register and tag-pipe valids: pop the head whenever the FIFO holds anything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fpu_i <= '0;
            r_vld_p <= '0;
        end else begin
            if (w_pop) begin
                r_fpu_i <= fpu_instruction_t'(w_head[FW-1:TAG_W]);
            end
            for (int i = FPU_LAT - 1; i > 0; i--) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
            r_vld_p[0] <= w_pop;
        end
    end

    // Tag payload travels alongside the valid bits; it is qualified by them, so no reset.
    always_ff @(posedge clk) begin
        for (int i = FPU_LAT - 1; i > 0; i--) begin
            r_tag_p[i] <= r_tag_p[i-1];
        end
        r_tag_p[0] <= w_head[TAG_W-1:0];
    end

    // Result capture and sticky flags; a capture in the same cycle as a clear restarts the sticky set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
            r_res_tag   <= '0;
            r_sticky    <= '0;
        end else begin
            r_res_valid <= w_cap;
            if (w_cap) begin
                r_res_data  <= fpu_out;
                r_res_flags <= fpu_flags;
                r_res_tag   <= r_tag_p[FPU_LAT-1];
                r_sticky    <= sticky_clr ? fpu_flags : (r_sticky | fpu_flags);
            end else if (sticky_clr) begin
                r_sticky    <= '0;
            end
        end
    end

    assign fpu_i        = r_fpu_i;
    assign res_valid    = r_res_valid;
    assign res_data     = r_res_data;
    assign res_flags    = fpu_flags_t'(r_res_flags);
    assign res_tag      = r_res_tag;
    assign sticky_flags = fpu_flags_t'(r_sticky);
    assign busy         = (w_count != '0) || (|r_vld_p) || r_res_valid;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with a behavioural fixed-latency FPU model.
module tb_fpu_dispatch;
    import definitions::*;

    localparam int LAT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    fpu_instruction_t in_instr = '0;
    logic [3:0]       in_tag = '0;
    fpu_instruction_t fpu_i;
    logic [31:0]      m_out;
    logic [7:0]       m_flags;
    logic             res_valid;
    float_t           res_data;
    fpu_flags_t       res_flags;
    logic [3:0]       res_tag;
    fpu_flags_t       sticky_flags;
    logic             sticky_clr = 1'b0;
    logic             busy;

    // Stand-alone FIFO used to exercise the full condition with a bench-controlled pop.
    logic             f_push = 1'b0;
    logic             f_pop = 1'b0;
    logic [7:0]       f_wdata = '0;
    logic [7:0]       f_rdata;
    logic [3:0]       f_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fpu_dispatch #(.DEPTH(8), .FPU_LAT(LAT), .TAG_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_tag       (in_tag),
        .fpu_i        (fpu_i),
        .fpu_out      (m_out),
        .fpu_flags    (m_flags),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_flags    (res_flags),
        .res_tag      (res_tag),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .busy         (busy)
    );

    fpu_instr_fifo #(.DEPTH(8), .W(8)) u_ff (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (f_push),
        .i_data  (f_wdata),
        .i_pop   (f_pop),
        .o_data  (f_rdata),
        .o_count (f_count)
    );

    // FPU model: a handful of known IEEE results, anything else returns opa+opb with no flags.
    function automatic logic [39:0] fpu_model(fpu_instruction_t ins);
        logic [39:0] r;
        r = {8'h00, ins.opa + ins.opb};
        if (ins.op == FPU_ADD && ins.opa == 32'h3F800000 && ins.opb == 32'h40000000)
            r = {8'h00, 32'h40400000};
        else if (ins.op == FPU_ADD && ins.opa == 32'h7F7FFFFF && ins.opb == 32'h7F7FFFFF)
            r = {8'h98, 32'h7F800000};
        else if (ins.op == FPU_SUB && ins.opa == ins.opb)
            r = {8'h02, 32'h00000000};
        else if (ins.op == FPU_MUL && ins.opa == 32'h40000000 && ins.opb == 32'h40000000)
            r = {8'h00, 32'h40800000};
        else if (ins.op == FPU_DIV && ins.opb == 32'h0)
            r = (ins.opa == 32'h0) ? {8'h20, 32'h7FC00000} : {8'h81, 32'h7F800000};
        return r;
    endfunction

    // LAT-1 registers after fpu_i so the result is stable in the cycle before the capture edge.
    fpu_instruction_t m_p [LAT-1];
    always @(posedge clk) begin
        m_p[0] <= fpu_i;
        for (int i = 1; i < LAT - 1; i++) m_p[i] <= m_p[i-1];
    end
    always_comb begin
        {m_flags, m_out} = fpu_model(m_p[LAT-2]);
    end

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [7:0]  flags;
        logic [3:0]  tag;
    } rec_t;
    rec_t q[$];
    rec_t mon_r;

    always @(negedge clk) begin
        if (res_valid) begin
            mon_r.cyc   = cyc;
            mon_r.data  = res_data;
            mon_r.flags = res_flags;
            mon_r.tag   = res_tag;
            q.push_back(mon_r);
        end
    end

    typedef struct {
        fpu_op_t     op;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [3:0]  tag;
        logic [31:0] exp_data;
        logic [7:0]  exp_flags;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic fpu_instruction_t mk(fpu_op_t op, logic [31:0] a, logic [31:0] b);
        fpu_instruction_t t;
        t.op = op;
        t.rmode = RM_NEAREST_EVEN;
        t.opa = a;
        t.opb = b;
        return t;
    endfunction

    initial begin
        int c0;
        fpu_instruction_t ins;

        vecs[0] = '{FPU_ADD, 32'h3F800000, 32'h40000000, 4'd3,  32'h40400000, 8'h00};
        vecs[1] = '{FPU_DIV, 32'h3F800000, 32'h00000000, 4'd9,  32'h7F800000, 8'h81};
        vecs[2] = '{FPU_SUB, 32'h3F800000, 32'h3F800000, 4'd5,  32'h00000000, 8'h02};
        vecs[3] = '{FPU_MUL, 32'h40000000, 32'h40000000, 4'd1,  32'h40800000, 8'h00};
        vecs[4] = '{FPU_DIV, 32'h00000000, 32'h00000000, 4'd12, 32'h7FC00000, 8'h20};
        vecs[5] = '{FPU_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'd15, 32'h7F800000, 8'h98};

        // Reset and idle state
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 72'(in_ready), 72'd1);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_res_valid", 72'(res_valid), 72'd0);
        chk("rst_fpu_i", 72'(fpu_i), 72'd0);
        chk("rst_sticky", 72'(sticky_flags), 72'd0);
        chk("rst_res_data", 72'(res_data), 72'd0);

        // Single operations from the vector table
        foreach (vecs[v]) begin
            q.delete();
            ins = mk(vecs[v].op, vecs[v].opa, vecs[v].opb);
            in_instr = ins;
            in_tag = vecs[v].tag;
            in_valid = 1'b1;
            sticky_clr = 1'b1;
            tick();
            c0 = cyc;
            in_valid = 1'b0;
            sticky_clr = 1'b0;
            chk("pre_issue_res_valid", 72'(res_valid), 72'd0);
            tick();
            chk("issue_fpu_i", 72'(fpu_i), 72'(ins));
            repeat (10) tick();
            chk("vec_count", 72'(q.size()), 72'd1);
            if (q.size() >= 1) begin
                chk("vec_latency", 72'(q[0].cyc - c0), 72'(1 + LAT));
                chk("vec_data", 72'(q[0].data), 72'(vecs[v].exp_data));
                chk("vec_flags", 72'(q[0].flags), 72'(vecs[v].exp_flags));
                chk("vec_tag", 72'(q[0].tag), 72'(vecs[v].tag));
            end
            chk("vec_sticky", 72'(sticky_flags), 72'(vecs[v].exp_flags));
            chk("vec_fpu_i_hold", 72'(fpu_i), 72'(ins));
            chk("vec_idle_busy", 72'(busy), 72'd0);
        end

        // Back-to-back burst of 8 with tags 0..7
        q.delete();
        c0 = 0;
        for (int k = 0; k < 8; k++) begin
            in_instr = mk(FPU_ADD, 32'h100 * k, 32'(k));
            in_tag = 4'(k);
            in_valid = 1'b1;
            chk("burst_in_ready", 72'(in_ready), 72'd1);
            tick();
            if (k == 0) c0 = cyc;
        end
        in_valid = 1'b0;
        repeat (12) tick();
        chk("burst_count", 72'(q.size()), 72'd8);
        if (q.size() == 8) begin
            chk("burst_latency", 72'(q[0].cyc - c0), 72'(1 + LAT));
            for (int k = 0; k < 8; k++) begin
                chk("burst_tag", 72'(q[k].tag), 72'(k));
                chk("burst_data", 72'(q[k].data), 72'(32'h101 * k));
                chk("burst_consec", 72'(q[k].cyc - q[0].cyc), 72'(k));
            end
        end
        chk("burst_busy_done", 72'(busy), 72'd0);

        // Sticky accumulation then clear coinciding with a capture
        q.delete();
        sticky_clr = 1'b1;
        in_instr = mk(FPU_DIV, 32'h3F800000, 32'h0);
        in_tag = 4'd9;
        in_valid = 1'b1;
        tick();
        c0 = cyc;
        sticky_clr = 1'b0;
        in_instr = mk(FPU_SUB, 32'h3F800000, 32'h3F800000);
        in_tag = 4'd4;
        tick();
        in_valid = 1'b0;
        repeat (LAT) tick();
        chk("stk_div_valid", 72'(res_valid), 72'd1);
        chk("stk_div_tag", 72'(res_tag), 72'd9);
        chk("stk_div_data", 72'(res_data), 72'h7F800000);
        chk("stk_div_sticky", 72'(sticky_flags), 72'h81);
        sticky_clr = 1'b1;
        tick();
        chk("stk_sub_tag", 72'(res_tag), 72'd4);
        chk("stk_sub_data", 72'(res_data), 72'h0);
        chk("stk_clr_capture", 72'(sticky_flags), 72'h02);
        tick();
        sticky_clr = 1'b0;
        chk("stk_clr_only", 72'(sticky_flags), 72'h00);
        chk("stk_no_strobe", 72'(res_valid), 72'd0);

        // Reset while three ops are in flight
        q.delete();
        for (int k = 0; k < 3; k++) begin
            in_instr = mk(FPU_ADD, 32'h10, 32'(k));
            in_tag = 4'(k + 10);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("mid_busy", 72'(busy), 72'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", 72'(busy), 72'd0);
        chk("mid_rst_fpu_i", 72'(fpu_i), 72'd0);
        repeat (10) tick();
        chk("mid_no_results", 72'(q.size()), 72'd0);
        chk("mid_ready", 72'(in_ready), 72'd1);

        // Stand-alone FIFO: overfill with no pops
        for (int k = 0; k < 10; k++) begin
            f_push = 1'b1;
            f_wdata = 8'hA0 + 8'(k);
            tick();
        end
        f_push = 1'b0;
        chk("ff_full_count", 72'(f_count), 72'd8);
        chk("ff_full_head", 72'(f_rdata), 72'hA0);
        f_pop = 1'b1;
        tick();
        chk("ff_pop_count", 72'(f_count), 72'd7);
        f_push = 1'b1;
        f_wdata = 8'hEE;
        tick();
        f_push = 1'b0;
        f_pop = 1'b0;
        chk("ff_pushpop_count", 72'(f_count), 72'd7);
        for (int k = 0; k < 7; k++) begin
            chk("ff_drain", 72'(f_rdata), (k < 6) ? 72'(8'hA2 + 8'(k)) : 72'hEE);
            f_pop = 1'b1;
            tick();
        end
        f_pop = 1'b0;
        chk("ff_empty", 72'(f_count), 72'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
